// File: rtl/binary_entry.sv
// Debounced binary word entry: bits are shifted in one push at a time.
// A completed WIDTH-bit word is handed to the consumer with a valid/ready handshake.
module binary_entry #(
  parameter int DB_CYCLES = 4,
  parameter int WIDTH     = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_btn,
  input  logic             clear_btn,
  input  logic             bit_sw,
  input  logic             out_ready,
  output logic [WIDTH-1:0] entry_bits,
  output logic [3:0]       bit_count,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid
);

  typedef enum logic {ENTRY, FULL} state_t;

  state_t state, state_n;

  logic [1:0] push_sync, clear_sync, sw_sync;

  // Index 0 is the push button, index 1 is the clear button.
  logic [1:0]      btn_s;
  logic [1:0][7:0] db_cnt;
  logic [1:0]      db_lvl, db_prev;
  logic            push_ev, clear_ev;

  logic [WIDTH-1:0] entry_bits_n, word_out_n, shifted;
  logic [3:0]       bit_count_n;
  logic             word_valid_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_sync  <= '0;
      clear_sync <= '0;
      sw_sync    <= '0;
    end else begin
      push_sync  <= {push_sync[0], push_btn};
      clear_sync <= {clear_sync[0], clear_btn};
      sw_sync    <= {sw_sync[0], bit_sw};
    end
  end

  assign btn_s = {clear_sync[1], push_sync[1]};

  // Level flips only after DB_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt  <= '0;
      db_lvl  <= '0;
      db_prev <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == 8'(DB_CYCLES - 1)) begin
          db_lvl[i] <= btn_s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
      db_prev <= db_lvl;
    end
  end

  assign push_ev  = db_lvl[0] & ~db_prev[0];
  assign clear_ev = db_lvl[1] & ~db_prev[1];
  assign shifted  = {entry_bits[WIDTH-2:0], sw_sync[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ENTRY;
      entry_bits <= '0;
      bit_count  <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      state      <= state_n;
      entry_bits <= entry_bits_n;
      bit_count  <= bit_count_n;
      word_out   <= word_out_n;
      word_valid <= word_valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    entry_bits_n = entry_bits;
    bit_count_n  = bit_count;
    word_out_n   = word_out;
    word_valid_n = word_valid;
    // Clear overrides a simultaneous push or transfer; word_out is never cleared.
    if (clear_ev) begin
      state_n      = ENTRY;
      entry_bits_n = '0;
      bit_count_n  = '0;
      word_valid_n = 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (push_ev) begin
            entry_bits_n = shifted;
            bit_count_n  = bit_count + 4'd1;
            if (bit_count == 4'(WIDTH - 1)) begin
              word_out_n   = shifted;
              word_valid_n = 1'b1;
              state_n      = FULL;
            end
          end
        end
        FULL: begin
          if (word_valid && out_ready) begin
            word_valid_n = 1'b0;
            entry_bits_n = '0;
            bit_count_n  = '0;
            state_n      = ENTRY;
          end
        end
        default: state_n = ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_entry.sv
// Scoreboard bench for binary_entry: completed words are queued as they are keyed in
// and popped when the DUT presents word_valid.
module tb_binary_entry;
  localparam int DB = 4;
  localparam int W  = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         push_btn = 1'b0, clear_btn = 1'b0, bit_sw = 1'b0, out_ready = 1'b0;
  logic [W-1:0] entry_bits, word_out;
  logic [3:0]   bit_count;
  logic         word_valid;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] last_word;

  binary_entry #(.DB_CYCLES(DB), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .push_btn(push_btn), .clear_btn(clear_btn),
    .bit_sw(bit_sw), .out_ready(out_ready), .entry_bits(entry_bits),
    .bit_count(bit_count), .word_out(word_out), .word_valid(word_valid)
  );

  always #5 clk = ~clk;

  // Full press/release; bit_sw is flipped after the event to show it is not resampled.
  task automatic press_bit(input logic b);
    @(negedge clk);
    bit_sw = b;
    push_btn = 1'b1;
    repeat (DB + 4) @(negedge clk);
    bit_sw = ~b;
    push_btn = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic press_clear();
    @(negedge clk);
    clear_btn = 1'b1;
    repeat (DB + 4) @(negedge clk);
    clear_btn = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (entry_bits !== '0) begin errors++; $display("FAIL reset_entry_bits got %h want 0", entry_bits); end
    checks++; if (bit_count !== 4'd0) begin errors++; $display("FAIL reset_bit_count got %0d want 0", bit_count); end
    checks++; if (word_out !== '0) begin errors++; $display("FAIL reset_word_out got %h want 0", word_out); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got %b want 0", word_valid); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timing();
    @(negedge clk);
    bit_sw = 1'b1;
    push_btn = 1'b1;
    for (int k = 0; k <= DB + 2; k++) begin
      @(negedge clk);
      checks++;
      if (bit_count !== ((k == DB + 2) ? 4'd1 : 4'd0) ||
          entry_bits !== ((k == DB + 2) ? 14'h0001 : 14'h0000)) begin
        errors++;
        $display("FAIL timing_E%0d got count=%0d bits=%h want count=%0d", k, bit_count, entry_bits,
                 (k == DB + 2) ? 1 : 0);
      end
    end
    push_btn = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic test_bounce();
    press_clear();
    bit_sw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_btn = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    checks++; if (bit_count !== 4'd0) begin errors++; $display("FAIL bounce_no_event got %0d want 0", bit_count); end
    push_btn = 1'b1;
    repeat (20) @(negedge clk);
    push_btn = 1'b0;
    repeat (DB + 4) @(negedge clk);
    checks++; if (bit_count !== 4'd1) begin errors++; $display("FAIL bounce_one_event got %0d want 1", bit_count); end
    checks++; if (entry_bits !== 14'h0000) begin errors++; $display("FAIL bounce_bits got %h want 0000", entry_bits); end
  endtask

  task automatic test_full_word();
    logic [W-1:0] pat, exp;
    logic [W-1:0] want;
    pat = 14'b10110011100101;
    exp = '0;
    press_clear();
    for (int i = W - 1; i >= 0; i--) begin
      press_bit(pat[i]);
      exp = {exp[W-2:0], pat[i]};
      if (i == 0) sb_q.push_back(exp);
      checks++;
      if (bit_count !== 4'(W - i) || entry_bits !== exp) begin
        errors++;
        $display("FAIL full_shift_%0d got count=%0d bits=%h want count=%0d bits=%h", W - i, bit_count, entry_bits, W - i, exp);
      end
      checks++;
      if (word_valid !== (i == 0)) begin errors++; $display("FAIL full_valid_%0d got %b want %b", W - i, word_valid, i == 0); end
    end
    checks++;
    if (sb_q.size() == 0) begin errors++; $display("FAIL full_sb_empty got 0 entries want 1"); end
    else begin
      want = sb_q.pop_front();
      if (word_out !== want) begin errors++; $display("FAIL full_word_out got %h want %h", word_out, want); end
    end
    press_bit(1'b0);
    checks++;
    if (bit_count !== 4'd14 || word_out !== 14'h2CE5 || entry_bits !== 14'h2CE5 || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_15th_push got count=%0d word=%h bits=%h valid=%b want 14/2ce5/2ce5/1", bit_count, word_out, entry_bits, word_valid);
    end
  endtask

  task automatic test_handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (word_valid !== 1'b0 || bit_count !== 4'd0 || entry_bits !== '0 || word_out !== 14'h2CE5) begin
      errors++;
      $display("FAIL handshake got valid=%b count=%0d bits=%h word=%h want 0/0/0/2ce5", word_valid, bit_count, entry_bits, word_out);
    end
    out_ready = 1'b1;
    press_bit(1'b1);
    checks++;
    if (word_valid !== 1'b0 || bit_count !== 4'd1) begin
      errors++;
      $display("FAIL entry_ignores_ready got valid=%b count=%0d want 0/1", word_valid, bit_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w, exp, want;
    press_clear();
    for (int n = 0; n < 2; n++) begin
      w = W'($urandom_range(1, 16383));
      exp = '0;
      for (int i = W - 1; i >= 0; i--) begin
        press_bit(w[i]);
        exp = {exp[W-2:0], w[i]};
      end
      sb_q.push_back(exp);
      checks++;
      if (word_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d got %b want 1", n, word_valid); end
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (sb_q.size() == 0) begin errors++; $display("FAIL b2b_sb_empty_%0d got 0 entries want 1", n); end
      else begin
        want = sb_q.pop_front();
        if (word_out !== want || word_valid !== 1'b0 || bit_count !== 4'd0) begin
          errors++;
          $display("FAIL b2b_word_%0d got word=%h valid=%b count=%0d want %h/0/0", n, word_out, word_valid, bit_count, want);
        end
      end
      last_word = exp;
    end
  endtask

  task automatic test_simultaneous();
    press_clear();
    for (int i = 0; i < 5; i++) press_bit(1'b1);
    checks++; if (bit_count !== 4'd5) begin errors++; $display("FAIL simul_setup got %0d want 5", bit_count); end
    @(negedge clk);
    bit_sw = 1'b1;
    push_btn = 1'b1;
    clear_btn = 1'b1;
    repeat (DB + 6) @(negedge clk);
    push_btn = 1'b0;
    clear_btn = 1'b0;
    repeat (DB + 4) @(negedge clk);
    checks++;
    if (bit_count !== 4'd0 || entry_bits !== '0) begin
      errors++;
      $display("FAIL simul_clear_wins got count=%0d bits=%h want 0/0", bit_count, entry_bits);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) press_bit(1'b1);
    checks++; if (bit_count !== 4'd9) begin errors++; $display("FAIL areset_setup got %0d want 9", bit_count); end
    checks++; if (word_out !== last_word) begin errors++; $display("FAIL areset_word_before got %h want %h", word_out, last_word); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    push_btn = 1'b1;
    bit_sw = 1'b1;
    #1;
    checks++;
    if (entry_bits !== '0 || bit_count !== 4'd0 || word_out !== '0 || word_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_outputs got bits=%h count=%0d word=%h valid=%b want all 0", entry_bits, bit_count, word_out, word_valid);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (bit_count !== 4'd1 || entry_bits !== 14'h0001) begin
      errors++;
      $display("FAIL areset_held_button got count=%0d bits=%h want 1/0001", bit_count, entry_bits);
    end
    push_btn = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_timing();
    test_bounce();
    test_full_word();
    test_handshake();
    test_back_to_back();
    test_simultaneous();
    test_async_reset();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d entries want 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
